// File: rtl/traffic_timer.sv
// traffic_timer: programmable base/extended/yellow second intervals, 1 s tick divider and countdown with expiry pulse.
// Define TIMER_READBACK_EN to add the tp_rd slot readback output.
module traffic_timer #(
  parameter int         TICK_DIV   = 10,
  parameter logic [3:0] T_BASE_DEF = 4'd6,
  parameter logic [3:0] T_EXT_DEF  = 4'd3,
  parameter logic [3:0] T_YEL_DEF  = 4'd2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       reprogram,
  input  logic [1:0] tp_sel,
  input  logic [3:0] t_val,
  input  logic [1:0] interval,
  input  logic       start_timer,
  output logic       expired,
  output logic       tick,
  output logic [3:0] remaining
`ifdef TIMER_READBACK_EN
  ,
  output logic [3:0] tp_rd
`endif
);
  localparam int DW = $clog2(TICK_DIV);
  typedef enum logic {IDLE, COUNT} state_t;
  state_t state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [3:0] base_q, base_d, ext_q, ext_d, yel_q, yel_d, rem_q, rem_d, load_val;
  logic tick_q, tick_d, exp_q, exp_d, wrap, start_ok, clr;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      div_q   <= '0;
      base_q  <= T_BASE_DEF;
      ext_q   <= T_EXT_DEF;
      yel_q   <= T_YEL_DEF;
      rem_q   <= 4'd0;
      tick_q  <= 1'b0;
      exp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      base_q  <= base_d;
      ext_q   <= ext_d;
      yel_q   <= yel_d;
      rem_q   <= rem_d;
      tick_q  <= tick_d;
      exp_q   <= exp_d;
    end
  end
  always_comb begin
    wrap     = div_q == DW'(TICK_DIV - 1);
    start_ok = start_timer && !reprogram;
    clr      = reprogram || start_ok;
    // a clearing edge restarts the second, so any tick due on it is dropped
    div_d    = (clr || wrap) ? '0 : div_q + DW'(1);
    tick_d   = wrap && !clr;
    base_d   = (reprogram && tp_sel == 2'b00) ? ((t_val == 4'd0) ? T_BASE_DEF : t_val) : base_q;
    ext_d    = (reprogram && tp_sel == 2'b01) ? ((t_val == 4'd0) ? T_EXT_DEF : t_val) : ext_q;
    yel_d    = (reprogram && tp_sel == 2'b10) ? ((t_val == 4'd0) ? T_YEL_DEF : t_val) : yel_q;
    load_val = (interval == 2'b01) ? ext_q : (interval == 2'b10) ? yel_q : base_q;
    state_d  = state_q;
    rem_d    = rem_q;
    exp_d    = 1'b0;
    if (reprogram) begin
      state_d = IDLE;
      rem_d   = 4'd0;
    end else if (start_timer) begin
      state_d = COUNT;
      rem_d   = load_val;
    end else if (state_q == COUNT && wrap) begin
      if (rem_q > 4'd1) begin
        rem_d = rem_q - 4'd1;
      end else begin
        rem_d   = 4'd0;
        exp_d   = 1'b1;
        state_d = IDLE;
      end
    end
  end
  assign expired   = exp_q;
  assign tick      = tick_q;
  assign remaining = rem_q;
`ifdef TIMER_READBACK_EN
  assign tp_rd = (tp_sel == 2'b00) ? base_q : (tp_sel == 2'b01) ? ext_q : (tp_sel == 2'b10) ? yel_q : 4'd0;
`endif
endmodule

// File: tb/tb_traffic_timer.sv
// tb_traffic_timer: directed plus random stimulus; expected expiry cycles are queued at issue time and a monitor scores them.
module tb_traffic_timer;
  localparam int TD = 10;
  typedef struct {int dl; bit valid;} ent_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic reprogram = 1'b0;
  logic [1:0] tp_sel = 2'd0;
  logic [3:0] t_val = 4'd0;
  logic [1:0] interval = 2'd0;
  logic start_timer = 1'b0;
  logic expired, tick;
  logic [3:0] remaining;
`ifdef TIMER_READBACK_EN
  logic [3:0] tp_rd;
`endif
  traffic_timer #(.TICK_DIV(TD)) dut (
    .clk(clk), .reset(reset), .reprogram(reprogram), .tp_sel(tp_sel), .t_val(t_val),
    .interval(interval), .start_timer(start_timer), .expired(expired), .tick(tick),
    .remaining(remaining)
`ifdef TIMER_READBACK_EN
    , .tp_rd(tp_rd)
`endif
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  // reference model state, written only by the stimulus process
  int defs[3] = '{6, 3, 2};
  int slot[3] = '{6, 3, 2};
  ent_t q[$];
  int cur_dl = -1;
  int last_clr = 0;
  bit mon_en = 1'b0;
  bit done = 1'b0;
  // scoreboard state, written only by the monitor process
  int checks = 0;
  int errors = 0;
  int rd = 0;
  bit fin = 1'b0;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask
  always @(negedge clk or posedge reset) begin
    if (clk) begin
      if (mon_en) begin
        #1;
        chk("async_rst_remaining", remaining, 0);
        chk("async_rst_expired", expired, 0);
        chk("async_rst_tick", tick, 0);
      end
    end else if (mon_en) begin
      while (rd < q.size() && !q[rd].valid) rd++;
      chk("expired", expired, (rd < q.size() && q[rd].dl == cyc) ? 1 : 0);
      if (rd < q.size() && q[rd].dl <= cyc) rd++;
      chk("remaining", remaining, (!reset && cur_dl > cyc) ? (cur_dl - cyc + TD - 1) / TD : 0);
      chk("tick", tick, (!reset && cyc > last_clr && (cyc - last_clr) % TD == 0) ? 1 : 0);
`ifdef TIMER_READBACK_EN
      chk("tp_rd", tp_rd, (tp_sel == 2'd3) ? 0 : slot[int'(tp_sel)]);
`endif
      if (done && !fin) begin
        int pend = 0;
        for (int i = rd; i < q.size(); i++) if (q[i].valid) pend++;
        chk("drained", pend, 0);
        fin = 1'b1;
      end
    end
  end
  task automatic cancel(input int thr);
    if (cur_dl >= thr) q[q.size()-1].valid = 1'b0;
    cur_dl = -1;
  endtask
  // drives one cycle of inputs, then applies the model at the edge that samples them
  task automatic step(input bit rp, input logic [1:0] sel, input logic [3:0] val, input logic [1:0] iv, input bit st);
    int k1;
    #2;
    reprogram = rp; tp_sel = sel; t_val = val; interval = iv; start_timer = st;
    @(posedge clk);
    k1 = cyc + 1;
    if (rp) begin
      if (sel != 2'd3) slot[int'(sel)] = (val == 4'd0) ? defs[int'(sel)] : int'(val);
      cancel(k1);
      last_clr = k1;
    end else if (st) begin
      cancel(k1);
      cur_dl = k1 + slot[(iv == 2'd3) ? 0 : int'(iv)] * TD;
      q.push_back('{cur_dl, 1'b1});
      last_clr = k1;
    end
  endtask
  task automatic idle(input int n);
    repeat (n) step(1'b0, 2'($urandom_range(0, 3)), 4'($urandom), 2'($urandom_range(0, 3)), 1'b0);
  endtask
  task automatic start(input logic [1:0] iv);
    step(1'b0, 2'd3, 4'd0, iv, 1'b1);
  endtask
  task automatic prog(input logic [1:0] sel, input logic [3:0] val);
    step(1'b1, sel, val, 2'd0, 1'b0);
  endtask
  task automatic rel_reset();
    #2;
    reset = 1'b0;
    last_clr = cyc;
    mon_en = 1'b1;
    @(posedge clk);
  endtask
  task automatic async_reset();
    #3;
    reprogram = 1'b0; start_timer = 1'b0; reset = 1'b1;
    cancel(cyc);
    slot = defs;
    @(posedge clk);
    @(posedge clk);
    rel_reset();
  endtask
  initial begin
    repeat (3) @(posedge clk);
    rel_reset();
    start(2'd0); idle(65);
    prog(2'd1, 4'd9); start(2'd1); idle(95);
    prog(2'd1, 4'd0); start(2'd1); idle(35);
    start(2'd2); idle(14); start(2'd0); idle(65);
    start(2'd3); idle(24); prog(2'd3, 4'd5); idle(100);
    step(1'b1, 2'd3, 4'd0, 2'd0, 1'b1); idle(20);
    prog(2'd0, 4'd12); start(2'd0); idle(32); async_reset();
    start(2'd0); idle(65);
    prog(2'd2, 4'd15); step(1'b0, 2'd2, 4'd0, 2'd0, 1'b0); prog(2'd2, 4'd0);
    idle(50);
    for (int i = 0; i < 150; i++) begin
      int op;
      op = $urandom_range(0, 9);
      if (op < 2) idle($urandom_range(1, 160));
      else if (op < 3) idle($urandom_range(1, 15));
      else if (op < 6) start(2'($urandom_range(0, 3)));
      else if (op < 8) prog(2'($urandom_range(0, 3)), 4'($urandom));
      else if (op == 8) step(1'b1, 2'($urandom_range(0, 3)), 4'($urandom), 2'($urandom_range(0, 3)), 1'b1);
      else if ($urandom_range(0, 2) == 0) async_reset();
      else idle(5);
    end
    idle(170);
    done = 1'b1;
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
